uart_rx_fifo: RTL
=================

// Module: uart_rx_fifo
// PURPOSE
//  8N1 UART receiver for the user project, clocked by the Wishbone clock.
//  Deserialises the line on mprj_io[5] (driven by the bench tbuart
//  transmitter) and buffers bytes in a small first-word-fall-through FIFO.
//  Read side uses a valid/ready handshake; frame and overrun errors are sticky.
// PARAMETERS
//  CLKS_PER_BIT  347  clocks per bit; 40 MHz / 115200 baud; must be >= 8
//  FIFO_DEPTH    4    FIFO entries; must be a power of 2 and >= 2
//  SYNC_STAGES   2    rx_i synchroniser flops; must be >= 2
// PORTS
//  wb_clk_i      in   1   system clock; all logic on the rising edge
//  wb_rst_i      in   1   reset, asynchronous, active-high
//  rx_i          in   1   serial input; idles high
//  rx_en_i       in   1   receiver enable
//  rx_data_o     out  8   head-of-FIFO byte; 8'h00 when FIFO is empty
//  rx_valid_o    out  1   FIFO not empty
//  rx_ready_i    in   1   consumer accept; pop when rx_valid_o & rx_ready_i
//  rx_count_o    out  $clog2(FIFO_DEPTH+1)  bytes held in the FIFO
//  rx_busy_o     out  1   FSM is not in IDLE
//  frame_err_o   out  1   sticky: a stop bit was sampled low
//  overrun_o     out  1   sticky: a byte was dropped because the FIFO was full
//  err_clear_i   in   1   1-cycle pulse; clears both sticky error flags
// BEHAVIOUR
//  Reset values: every output is 0, the synchroniser flops are 1, FSM is IDLE,
//   FIFO is empty.
//  Synchroniser: rx_i passes through SYNC_STAGES flops to give rx_s. Every
//   sample uses rx_s.
//  FSM states: IDLE, START, DATA, STOP, WAIT_HI. bit_cnt counts 0..CLKS_PER_BIT-1.
//  - IDLE: when rx_en_i=1 and rx_s=0, go to START with bit_cnt=0.
//  - START: at bit_cnt == CLKS_PER_BIT/2-1 (integer division), sample rx_s.
//    If rx_s=1 it is a false start: return to IDLE. If rx_s=0, clear bit_cnt
//    and go to DATA.
//  - DATA: sample at each bit_cnt wrap (CLKS_PER_BIT-1), so samples fall at
//    mid-bit. Bits arrive LSB first into a shift register. After the 8th
//    sample, go to STOP.
//  - STOP: sample at the wrap.
//    rx_s=1: push the byte and go to IDLE immediately, half a bit early, to
//    allow resync.
//    rx_s=0: set frame_err_o, discard the byte, go to WAIT_HI.
//  - WAIT_HI: stay until rx_s=1 (break or held-low line), then go to IDLE.
//  rx_en_i=0 in any state: the next state is IDLE and any partial frame is
//   dropped. FIFO contents and error flags are kept.
//  Latency: a pushed byte drives rx_valid_o=1 and rx_data_o on the cycle after
//   the stop sample, when the FIFO was empty.
//  FIFO:
//   - Read/write pointers are log2(FIFO_DEPTH) bits and wrap modulo the depth.
//   - A push is accepted when count < FIFO_DEPTH, or when a pop happens in the
//     same cycle. In that case count is unchanged and order is preserved.
//   - If a push is refused, the byte is lost and overrun_o is set.
//   - A pop with a push on the same cycle at count=1 keeps rx_valid_o=1 and
//     shows the new byte.
//   - rx_ready_i has no effect while rx_valid_o=0.
//  Error flags: err_clear_i clears both flags on the next cycle. If a new error
//   arrives in the same cycle as err_clear_i, the error wins and the flag stays 1.
//  Reset mid-frame: the frame is abandoned and the FIFO is emptied at once. The
//   next full frame after the line has been idle is received correctly.
// TESTING  (bench overrides CLKS_PER_BIT=16)
//  1. Send 0x3D 8N1, rx_ready_i=0 -> one cycle after the stop sample:
//     rx_valid_o=1, rx_data_o=0x3D, rx_count_o=1. Pulse rx_ready_i -> valid=0.
//  2. rx_i low for 4 clocks, then high -> no push, rx_busy_o back to 0 within
//     SYNC_STAGES+8 clocks, no error flags.
//  3. Send 0xA5 with a low stop bit, line held low for 40 clocks -> frame_err_o=1,
//     count=0, FSM in WAIT_HI until the line goes high. err_clear_i -> flag 0.
//  4. Send 0x01..0x05 with rx_ready_i=0 -> count=4, overrun_o=1. Pops return
//     0x01..0x04 in order; 0x05 is absent.
//  5. FIFO full; rx_ready_i=1 exactly on the cycle 0x06 is pushed -> no overrun,
//     count stays 4, later pops return 0x02,0x03,0x04,0x06.
//  6. Assert wb_rst_i in the middle of DATA for 0x7E -> every output is 0. A
//     following 0x00 then 0xFF sent back-to-back with no idle gap are both
//     received, no errors.

Source files
------------

// File: rtl/uart_rx_fifo.sv
`default_nettype none
// +------------------------------------------------------------------+
// | uart_rx_fifo : 8N1 UART receiver feeding a small FWFT byte FIFO   |
// | rev 1.0                                                           |
// +------------------------------------------------------------------+
module uart_rx_fifo #(
  parameter int CLKS_PER_BIT = 347,
  parameter int FIFO_DEPTH   = 4,
  parameter int SYNC_STAGES  = 2
) (
  input  logic                           wb_clk_i,
  input  logic                           wb_rst_i,
  input  logic                           rx_i,
  input  logic                           rx_en_i,
  output logic [7:0]                     rx_data_o,
  output logic                           rx_valid_o,
  input  logic                           rx_ready_i,
  output logic [$clog2(FIFO_DEPTH+1)-1:0] rx_count_o,
  output logic                           rx_busy_o,
  output logic                           frame_err_o,
  output logic                           overrun_o,
  input  logic                           err_clear_i
);

  localparam int CNT_W  = $clog2(CLKS_PER_BIT);
  localparam int PTR_W  = $clog2(FIFO_DEPTH);
  localparam int CNTF_W = $clog2(FIFO_DEPTH+1);
  localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLKS_PER_BIT / 2 - 1);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    START   = 3'd1,
    DATA    = 3'd2,
    STOP    = 3'd3,
    WAIT_HI = 3'd4
  } state_t;

  state_t                 state, state_nxt;
  logic [SYNC_STAGES-1:0] sync;
  logic                   rx_s;
  logic [CNT_W-1:0]       bit_cnt, bit_cnt_nxt;
  logic [2:0]             bit_idx, bit_idx_nxt;
  logic [7:0]             shift, shift_nxt;
  logic                   push, frame_set;

  logic [7:0]             mem [FIFO_DEPTH];
  logic [PTR_W-1:0]       wr_ptr, rd_ptr;
  logic [CNTF_W-1:0]      count;
  logic                   pop, push_ok;

  // Line idles high, so the synchroniser resets to ones to avoid a false start.
  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) sync <= '1;
    else          sync <= {sync[SYNC_STAGES-2:0], rx_i};
  end

  assign rx_s = sync[SYNC_STAGES-1];

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      state   <= IDLE;
      bit_cnt <= '0;
      bit_idx <= '0;
      shift   <= '0;
    end else begin
      state   <= state_nxt;
      bit_cnt <= bit_cnt_nxt;
      bit_idx <= bit_idx_nxt;
      shift   <= shift_nxt;
    end
  end

  always_comb begin
    state_nxt   = state;
    bit_cnt_nxt = bit_cnt;
    bit_idx_nxt = bit_idx;
    shift_nxt   = shift;
    push        = 1'b0;
    frame_set   = 1'b0;
    case (state)
      IDLE: begin
        if (!rx_s) begin
          state_nxt   = START;
          bit_cnt_nxt = '0;
        end
      end
      START: begin
        if (bit_cnt == HALF_LAST) begin
          if (rx_s) begin
            state_nxt = IDLE;
          end else begin
            state_nxt   = DATA;
            bit_cnt_nxt = '0;
            bit_idx_nxt = '0;
          end
        end else begin
          bit_cnt_nxt = bit_cnt + CNT_W'(1);
        end
      end
      DATA: begin
        if (bit_cnt == BIT_LAST) begin
          bit_cnt_nxt = '0;
          shift_nxt   = {rx_s, shift[7:1]};
          bit_idx_nxt = bit_idx + 3'd1;
          if (bit_idx == 3'd7) state_nxt = STOP;
        end else begin
          bit_cnt_nxt = bit_cnt + CNT_W'(1);
        end
      end
      STOP: begin
        // Leaving at mid-stop-bit gives half a bit of slack to catch the next start edge.
        if (bit_cnt == BIT_LAST) begin
          if (rx_s) begin
            push      = 1'b1;
            state_nxt = IDLE;
          end else begin
            frame_set = 1'b1;
            state_nxt = WAIT_HI;
          end
        end else begin
          bit_cnt_nxt = bit_cnt + CNT_W'(1);
        end
      end
      WAIT_HI: begin
        if (rx_s) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
    if (!rx_en_i) begin
      state_nxt = IDLE;
      push      = 1'b0;
      frame_set = 1'b0;
    end
  end

  assign rx_valid_o = (count != '0);
  assign pop        = rx_valid_o & rx_ready_i;
  assign push_ok    = push & ((count != CNTF_W'(FIFO_DEPTH)) | pop);

  always_ff @(posedge wb_clk_i) begin
    if (push_ok) mem[wr_ptr] <= shift;
  end

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)     rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push_ok, pop})
        2'b10:   count <= count + CNTF_W'(1);
        2'b01:   count <= count - CNTF_W'(1);
        default: count <= count;
      endcase
    end
  end

  // A new error in the clear cycle takes priority so it is never lost.
  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      frame_err_o <= 1'b0;
      overrun_o   <= 1'b0;
    end else begin
      if (frame_set)        frame_err_o <= 1'b1;
      else if (err_clear_i) frame_err_o <= 1'b0;
      if (push & ~push_ok)  overrun_o   <= 1'b1;
      else if (err_clear_i) overrun_o   <= 1'b0;
    end
  end

  assign rx_data_o  = rx_valid_o ? mem[rd_ptr] : 8'h00;
  assign rx_count_o = count;
  assign rx_busy_o  = (state != IDLE);

endmodule
`default_nettype wire
